muldiv_hilo_unit: RTL and testbench
===================================

# muldiv_hilo_unit

Multi-cycle multiply/divide engine that owns the architectural HI/LO registers of the 5-stage MIPS pipeline. It sits beside the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and drives `busy` so the stall logic can hold ID/EX. It also supplies the result and the `hiwrite`/`lowrite` qualifiers that the forwarding/hazard unit consumes for HI/LO bypass.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI/LO are `WIDTH` bits each, and the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  op issue strobe from EX, sampled at the rising edge.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are ignored.
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MT source).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `flush`  in  1  abort the in-flight op (exception or redirect).
- `busy`  out  1  unit occupied; stall any HI/LO consumer or new issue.
- `done`  out  1  one-cycle completion pulse.
- `hiwrite`, `lowrite`  out  1 each  asserted together with `done`.
- `res_hi`, `res_lo`  out  WIDTH  pending results; valid only while `done`=1, used for forwarding.
- `hi`, `lo`  out  WIDTH  architectural registers.

## Operation
- States: IDLE, RUN, DONE. Iteration counter is 0..WIDTH-1.
- IDLE with `start`=1 and `flush`=0:
  - MT ops: write `a` into HI (MTHI) or LO (MTLO) at that edge. State stays IDLE. No `done` pulse.
  - Mul/div ops: latch |a|, |b|, the sign flags and the op. Clear the counter. Go to RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. After the WIDTH-th step, go to DONE.
- DONE: `done`=`hiwrite`=`lowrite`=1, and `res_hi`/`res_lo` hold the final values. HI/LO load at the edge that leaves DONE. Next state is IDLE.
- Multiply result: 2·WIDTH-bit product; HI gets the upper half, LO the lower half. For MULT, negate the product when sign(a)≠sign(b).
- Divide result: LO = quotient, HI = remainder.
  - DIV: quotient is negated when signs differ. Remainder takes the sign of the dividend.
- Divide by zero, signed or unsigned: LO = all-ones, HI = `a`. Latency is unchanged.
- DIV 0x80000000 / -1: LO = 0x80000000, HI = 0.
- `busy` = (state ≠ IDLE). `start` while busy is ignored.
- `flush` = 1 in RUN or DONE: go to IDLE at the next edge. `done`, `hiwrite` and `lowrite` are forced to 0 that cycle. HI/LO are unchanged.
- `flush` = 1 in IDLE: a coincident `start` is ignored, including MT ops.

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `hi`, `lo`, `res_hi`, `res_lo` = 0.
  - `busy`, `done`, `hiwrite`, `lowrite` = 0.
- Reset mid-operation discards the op immediately (asynchronous).
- Mul/div, with issue edge E0:
  - RUN during cycles E0..E(WIDTH).
  - DONE during the cycle after edge E(WIDTH).
  - HI/LO updated at edge E(WIDTH+1).
  - `busy` is high for WIDTH+1 cycles.
- MT ops: HI/LO update at the issue edge, visible the next cycle, 0 busy cycles.
- An MT op and DONE cannot overlap, because `start` is ignored while busy.
- `done`, `hiwrite`, `lowrite` are registered-state decodes, high for exactly one cycle.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle combinational multiplier and go from IDLE directly to DONE. `busy` is high for 1 cycle; HI/LO update at E1.
  - Divide is unaffected.
- `MULDIV_FAST_MUL_EN` undefined: multiply is iterative, with the same WIDTH+1-cycle latency as divide.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after latency, HI=0xFFFFFFFE, LO=0x00000001. `done` high for exactly 1 cycle. `busy` high for 33 cycles (1 with `MULDIV_FAST_MUL_EN`).
- MULT a=-7 (0xFFFFFFF9), b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. `res_hi`/`res_lo` match during `done`.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=0x00000007.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive edges -> hi/lo are updated the cycle after each issue. `busy` stays 0 and `done` stays 0.
- Issue DIV, assert `flush` at cycle 10, and drive `start` with a MULT while busy -> unit returns to IDLE. No `done` pulse. HI/LO keep their prior values. The ignored MULT never executes.
- Assert `rst` asynchronously mid-RUN -> all outputs are 0 immediately. A following DIVU 100/7 gives LO=14, HI=2.

Source files
------------

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit
//   Multi-cycle multiply/divide engine owning the architectural HI/LO
//   registers. Sits beside EX, accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO and
//   reports occupancy and completion for stall and HI/LO forwarding logic.
//
//   Ports:
//     clk, rst          rising-edge clock, asynchronous active-high reset
//     start, op         issue strobe and opcode (000 MULT, 001 MULTU,
//                       010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored)
//     a, b              rs / rt operands
//     flush             abort the in-flight op
//     busy              unit occupied (state != IDLE)
//     done              one-cycle completion pulse
//     hiwrite, lowrite  HI/LO write qualifiers, equal to done
//     res_hi, res_lo    pending results, valid while done=1
//     hi, lo            architectural HI/LO
//
//   Build option: define MULDIV_FAST_MUL_EN to perform MULT/MULTU with a
//   single-cycle combinational multiplier (IDLE -> DONE directly).
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             hiwrite,
  output logic             lowrite,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             is_div, a_neg, b_neg;

  // Sign/magnitude correction of the unsigned multiply result.
  function automatic logic [2*WIDTH-1:0] fix_mul(input logic [2*WIDTH-1:0] p,
                                                 input logic neg);
    return neg ? -p : p;
  endfunction

  // Sign correction of the unsigned divide result, returned as {hi, lo}.
  // With a zero divisor the restoring loop leaves q = all-ones and r = |a|,
  // so re-applying the dividend sign to r reproduces the original a.
  function automatic logic [2*WIDTH-1:0] fix_div(input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] r,
                                                 input logic [WIDTH-1:0] d,
                                                 input logic an,
                                                 input logic bn);
    logic [WIDTH-1:0] r_s;
    r_s = an ? -r : r;
    if (d == '0) return {r_s, {WIDTH{1'b1}}};
    return {r_s, ((an ^ bn) ? -q : q)};
  endfunction

  // Issue decode
  logic             issue, issue_md, sgn_in, a_neg_in, b_neg_in;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign issue    = start & ~flush & (state == IDLE);
  assign issue_md = issue & ~op[2];
  assign sgn_in   = ~op[0];
  assign a_neg_in = sgn_in & a[WIDTH-1];
  assign b_neg_in = sgn_in & b[WIDTH-1];
  assign abs_a    = a_neg_in ? -a : a;
  assign abs_b    = b_neg_in ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif

  // Iteration datapath
  logic [WIDTH:0] mul_sum, div_shift, div_diff;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  // Final results
  logic [WIDTH-1:0] fin_hi, fin_lo;

  always_comb begin
    if (is_div) {fin_hi, fin_lo} = fix_div(acc_lo, acc_hi, opnd, a_neg, b_neg);
    else        {fin_hi, fin_lo} = fix_mul({acc_hi, acc_lo}, a_neg ^ b_neg);
  end

  // FSM next state and outputs
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (issue_md) begin
`ifdef MULDIV_FAST_MUL_EN
          state_nxt = op[1] ? RUN : DONE;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        if (flush)                          state_nxt = IDLE;
        else if (cnt == CW'(WIDTH - 1))     state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        done      = ~flush;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign hiwrite = done;
  assign lowrite = done;
  assign res_hi  = (state == DONE) ? fin_hi : '0;
  assign res_lo  = (state == DONE) ? fin_lo : '0;

  // Control state and architectural HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      if (issue_md)           cnt <= '0;
      else if (state == RUN)  cnt <= cnt + CW'(1);
      if (issue && op == 3'b100) hi <= a;
      if (issue && op == 3'b101) lo <= a;
      if (done) begin
        hi <= fin_hi;
        lo <= fin_lo;
      end
    end
  end

  // Operand latch and iteration step: multiply keeps the multiplier in
  // acc_lo and shifts the partial product right; divide shifts the
  // dividend out of acc_lo into the remainder while quotient bits enter.
  always_ff @(posedge clk) begin
    if (issue_md) begin
      is_div <= op[1];
      a_neg  <= a_neg_in;
      b_neg  <= b_neg_in;
      acc_hi <= '0;
      if (op[1]) begin
        opnd   <= abs_b;
        acc_lo <= abs_a;
      end else begin
        opnd   <= abs_a;
`ifdef MULDIV_FAST_MUL_EN
        {acc_hi, acc_lo} <= fast_prod;
`else
        acc_lo <= abs_b;
`endif
      end
    end else if (state == RUN) begin
      if (is_div) begin
        acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
module tb_muldiv_hilo_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, hiwrite, lowrite;
  logic [W-1:0] res_hi, res_lo, hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hiwrite(hiwrite),
    .lowrite(lowrite), .res_hi(res_hi), .res_lo(res_lo), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: architectural results straight from integer arithmetic
  function automatic void ref_op(input logic [2:0] o, input logic [31:0] x,
                                 input logic [31:0] y,
                                 output logic [31:0] rh, output logic [31:0] rl);
    int          sx, sy;
    longint      sp;
    logic [63:0] up;
    sx = x; sy = y;
    rh = '0; rl = '0;
    case (o)
      3'd0: begin sp = longint'(sx) * longint'(sy); {rh, rl} = sp; end
      3'd1: begin up = {32'b0, x} * {32'b0, y}; {rh, rl} = up; end
      3'd2: begin
        if (y == 0) begin rl = 32'hFFFFFFFF; rh = x; end
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin rl = x; rh = 0; end
        else begin rl = 32'(sx / sy); rh = 32'(sx % sy); end
      end
      default: begin
        if (y == 0) begin rl = 32'hFFFFFFFF; rh = x; end
        else begin rl = x / y; rh = x % y; end
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] o);
`ifdef MULDIV_FAST_MUL_EN
    if (o < 3'd2) return 1;
`endif
    return W + 1;
  endfunction

  // Issue one mul/div op and check the whole transaction
  task automatic run_md(input string nm, input logic [2:0] o,
                        input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eh, el, ch, cl;
    int          busy_n, done_n, wr_n;
    ref_op(o, x, y, eh, el);
    @(negedge clk); start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); start = 1'b0;
    busy_n = 0; done_n = 0; wr_n = 0; ch = '0; cl = '0;
    for (int i = 0; i < 100 && busy; i++) begin
      busy_n++;
      if (done) begin
        done_n++; ch = res_hi; cl = res_lo;
        if (hiwrite && lowrite) wr_n++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (busy_n !== exp_latency(o)) begin
      n_bad++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, busy_n, exp_latency(o));
    end
    n_cmp++;
    if (done_n !== 1 || wr_n !== 1) begin
      n_bad++; $display("FAIL %s done_pulse: got done=%0d wr=%0d want 1/1", nm, done_n, wr_n);
    end
    n_cmp++;
    if (ch !== eh || cl !== el) begin
      n_bad++; $display("FAIL %s res: got %h_%h want %h_%h", nm, ch, cl, eh, el);
    end
    n_cmp++;
    if (hi !== eh || lo !== el) begin
      n_bad++; $display("FAIL %s hilo: got %h_%h want %h_%h (a=%h b=%h op=%0d)",
                        nm, hi, lo, eh, el, x, y, o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, hiwrite, lowrite} !== 4'b0 || hi !== 0 || lo !== 0 ||
        res_hi !== 0 || res_lo !== 0) begin
      n_bad++; $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h want all 0",
                        busy, done, hi, lo);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    run_md("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_md("mult_neg7x3", 3'd0, 32'hFFFFFFF9, 32'd3);
    run_md("div_neg7_2", 3'd2, 32'hFFFFFFF9, 32'd2);
    run_md("divu_by0", 3'd3, 32'd7, 32'd0);
    run_md("div_neg_by0", 3'd2, 32'hFFFFFFF9, 32'd0);
    run_md("div_min_m1", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_md("mult_min_min", 3'd0, 32'h80000000, 32'h80000000);
  endtask

  task automatic test_mt();
    @(negedge clk); start = 1'b1; op = 3'd4; a = 32'h12345678;
    @(negedge clk);
    n_cmp++;
    if (hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL mthi: got hi=%h busy=%b done=%b want 12345678/0/0", hi, busy, done);
    end
    op = 3'd5; a = 32'h9ABCDEF0;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b want 12345678/9abcdef0/0/0",
                        hi, lo, busy, done);
    end
  endtask

  task automatic test_ignored_ops();
    logic [31:0] ph, pl;
    for (int i = 0; i < 4; i++) begin
      ph = hi; pl = lo;
      @(negedge clk); start = 1'b1; op = 3'd6 + 3'(i & 1); a = $urandom; b = $urandom;
      @(negedge clk); start = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || hi !== ph || lo !== pl) begin
        n_bad++; $display("FAIL ignored_op%0d: got busy=%b hi=%h lo=%h want 0/%h/%h",
                          op, busy, hi, lo, ph, pl);
      end
    end
  endtask

  task automatic test_flush_run();
    logic [31:0] ph, pl;
    int          dn;
    ph = hi; pl = lo; dn = 0;
    @(negedge clk); start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
    @(negedge clk); op = 3'd0; a = 32'd3; b = 32'd5;  // MULT held while busy
    for (int i = 0; i < 9; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || dn !== 0) begin
      n_bad++; $display("FAIL flush_run_idle: got busy=%b done_seen=%0d want 0/0", busy, dn);
    end
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dn++;
      @(negedge clk);
    end
    n_cmp++;
    if (hi !== ph || lo !== pl || dn !== 0) begin
      n_bad++; $display("FAIL flush_run_hilo: got %h_%h activity=%0d want %h_%h 0",
                        hi, lo, dn, ph, pl);
    end
  endtask

  task automatic test_flush_done();
    logic [31:0] ph, pl;
    int          k;
    ph = hi; pl = lo;
    @(negedge clk); start = 1'b1; op = 3'd3; a = 32'd99; b = 32'd4;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!done && k < 100) begin @(negedge clk); k++; end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL flush_done_reach: got done=%b want 1", done);
    end
    flush = 1'b1;
    #1;
    n_cmp++;
    if (done !== 1'b0 || hiwrite !== 1'b0 || lowrite !== 1'b0) begin
      n_bad++; $display("FAIL flush_done_mask: got %b%b%b want 000", done, hiwrite, lowrite);
    end
    @(negedge clk); flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || hi !== ph || lo !== pl) begin
      n_bad++; $display("FAIL flush_done_hilo: got busy=%b %h_%h want 0 %h_%h",
                        busy, hi, lo, ph, pl);
    end
  endtask

  task automatic test_flush_idle();
    logic [31:0] ph;
    ph = hi;
    @(negedge clk); start = 1'b1; op = 3'd4; a = ~ph; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    n_cmp++;
    if (hi !== ph || busy !== 1'b0) begin
      n_bad++; $display("FAIL flush_idle_mt: got hi=%h busy=%b want %h 0", hi, busy, ph);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); start = 1'b1; op = 3'd2; a = 32'd12345; b = 32'd17;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, hiwrite, lowrite} !== 4'b0 || hi !== 0 || lo !== 0 ||
        res_hi !== 0 || res_lo !== 0) begin
      n_bad++; $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h want all 0",
                        busy, done, hi, lo);
    end
    @(negedge clk); rst = 1'b0;
    run_md("divu_100_7", 3'd3, 32'd100, 32'd7);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    case ($urandom_range(0, 3))
      0:       return corners[$urandom_range(0, 4)];
      1:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_md("random", 3'($urandom_range(0, 3)), pick(), pick());
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt();
    test_ignored_ops();
    test_flush_run();
    test_flush_done();
    test_flush_idle();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
